// File: rtl/act_repeat_buffer_pkg.sv
// Shared types and helpers for the activation repeat buffer.
// Config fields are held 32 bits wide so one struct serves every parameterisation.
package act_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] load_len;
    logic [31:0] line_len;
    logic [31:0] line_stride;
    logic [31:0] line_num;
    logic [31:0] rep;
    logic [31:0] full_rep;
  } cfg_t;

  function automatic int unsigned sub_count(input int unsigned in_w,
                                            input int unsigned lanes,
                                            input int unsigned lane_bits);
    return in_w / (lanes * lane_bits);
  endfunction

  // Replicates bit (bits-1) of v into every position above it.
  function automatic logic [31:0] sign_ext(input logic [31:0] v, input int unsigned bits);
    logic [31:0] mask;
    logic        sgn;
    mask = (bits >= 32) ? '0 : ('1 << bits);
    sgn  = v[5'(bits - 1)];
    return sgn ? (v | mask) : (v & ~mask);
  endfunction

endpackage

// File: rtl/act_rbuf_ram.sv
// Simple dual-port buffer RAM: write port A, registered read port B (1-cycle latency).
module act_rbuf_ram #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 65536,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/act_repeat_buffer.sv
// Loads one activation tile into a buffer, then replays lines and the whole tile
// as sign-extended lane beats, with credit-based reads into a 2-entry skid FIFO.
module act_repeat_buffer
  import act_pkg::*;
#(
  parameter int unsigned IN_W      = 128,
  parameter int unsigned LANES     = 4,
  parameter int unsigned LANE_BITS = 16,
  parameter int unsigned ACT_BITS  = 12,
  parameter int unsigned OUT_BITS  = 16,
  parameter int unsigned DEPTH     = 65536,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter int unsigned CW        = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [AW:0]               cfg_load_len,
  input  logic [AW-1:0]             cfg_line_len,
  input  logic [AW-1:0]             cfg_line_stride,
  input  logic [CW-1:0]             cfg_line_num,
  input  logic [CW-1:0]             cfg_repeat,
  input  logic [CW-1:0]             cfg_full_repeat,
  input  logic                      s_act_tvalid,
  output logic                      s_act_tready,
  input  logic [IN_W-1:0]           s_act_tdata,
  input  logic                      s_act_tlast,
  output logic                      m_act_tvalid,
  input  logic                      m_act_tready,
  output logic [LANES*OUT_BITS-1:0] m_act_tdata,
  output logic                      m_act_tlast,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                status
);

  localparam int unsigned SUB = sub_count(IN_W, LANES, LANE_BITS);
  localparam int unsigned SW  = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int unsigned DW  = LANES * OUT_BITS;

  state_t        state;
  cfg_t          cfg;
  logic [AW:0]   wptr;
  logic [SW-1:0] sub_i;
  logic [AW-1:0] word_i;
  logic [CW-1:0] rep_i, line_i, pass_i;
  logic [AW:0]   line_base;
  logic          all_issued;

  logic          rd_vld, rd_last;
  logic [SW-1:0] rd_sub;

  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          fifo_wsel, fifo_rsel;
  logic [1:0]    fifo_cnt;

  logic          ram_we;
  logic [AW-1:0] ram_raddr;
  logic [IN_W-1:0] ram_rdata;
  logic [DW-1:0] push_data;

  logic [31:0] rep_n, full_n;
  logic        last_sub, last_word, last_rep, last_line, last_pass;
  logic [AW:0] addr_sum;
  logic        addr_ovf;
  logic        pop, issue, load_acc, skip_in, skip_cfg;
  logic [1:0]  occ;

  assign rep_n     = (cfg.rep == '0) ? 32'd1 : cfg.rep;
  assign full_n    = (cfg.full_rep == '0) ? 32'd1 : cfg.full_rep;
  assign last_sub  = (32'(sub_i) == SUB - 1);
  assign last_word = (32'(word_i) == cfg.line_len - 32'd1);
  assign last_rep  = (32'(rep_i) == rep_n - 32'd1);
  assign last_line = (32'(line_i) == cfg.line_num - 32'd1);
  assign last_pass = (32'(pass_i) == full_n - 32'd1);
  assign skip_in   = (cfg_line_len == '0) || (cfg_line_num == '0);
  assign skip_cfg  = (cfg.line_len == '0) || (cfg.line_num == '0);

  assign addr_sum  = line_base + {1'b0, word_i};
  assign addr_ovf  = (addr_sum >= (AW+1)'(DEPTH));
  assign ram_raddr = addr_ovf ? AW'(addr_sum - (AW+1)'(DEPTH)) : addr_sum[AW-1:0];

  // Occupancy is taken after this cycle's pop so a steady stream sustains 1 beat/clk.
  assign pop      = (fifo_cnt != 2'd0) && m_act_tready;
  assign occ      = fifo_cnt - {1'b0, pop};
  assign issue    = (state == ST_STREAM) && !all_issued && ((occ + {1'b0, rd_vld}) < 2'd2);
  assign load_acc = s_act_tvalid && s_act_tready;
  assign ram_we   = load_acc && (wptr < (AW+1)'(DEPTH));

  act_rbuf_ram #(
    .W     (IN_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr[AW-1:0]),
    .wdata (s_act_tdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    push_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      push_data[k*OUT_BITS +: OUT_BITS] = OUT_BITS'(sign_ext(
        32'(ACT_BITS'(ram_rdata >> ((32'(rd_sub) * LANES + k) * LANE_BITS))), ACT_BITS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cfg          <= '0;
      wptr         <= '0;
      sub_i        <= '0;
      word_i       <= '0;
      rep_i        <= '0;
      line_i       <= '0;
      pass_i       <= '0;
      line_base    <= '0;
      all_issued   <= 1'b0;
      rd_vld       <= 1'b0;
      rd_sub       <= '0;
      rd_last      <= 1'b0;
      cfg_ready    <= 1'b1;
      s_act_tready <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= issue;
      if (issue) begin
        rd_sub  <= sub_i;
        rd_last <= last_sub && last_word;
        if (addr_ovf) err <= 1'b1;
        if (!last_sub) sub_i <= sub_i + 1'b1;
        else begin
          sub_i <= '0;
          if (!last_word) word_i <= word_i + 1'b1;
          else begin
            word_i <= '0;
            if (!last_rep) rep_i <= rep_i + 1'b1;
            else begin
              rep_i <= '0;
              if (!last_line) begin
                line_i    <= line_i + 1'b1;
                line_base <= (AW+1)'(32'(line_base) + cfg.line_stride);
              end else begin
                line_i    <= '0;
                line_base <= '0;
                if (!last_pass) pass_i <= pass_i + 1'b1;
                else begin
                  pass_i     <= '0;
                  all_issued <= 1'b1;
                end
              end
            end
          end
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            cfg <= '{load_len:    32'(cfg_load_len),
                     line_len:    32'(cfg_line_len),
                     line_stride: 32'(cfg_line_stride),
                     line_num:    32'(cfg_line_num),
                     rep:         32'(cfg_repeat),
                     full_rep:    32'(cfg_full_repeat)};
            err        <= 1'b0;
            wptr       <= '0;
            sub_i      <= '0;
            word_i     <= '0;
            rep_i      <= '0;
            line_i     <= '0;
            pass_i     <= '0;
            line_base  <= '0;
            all_issued <= 1'b0;
            cfg_ready  <= 1'b0;
            if (cfg_load_len != '0) begin
              state        <= ST_LOAD;
              s_act_tready <= 1'b1;
            end else if (skip_in) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        ST_LOAD: begin
          if (load_acc) begin
            wptr <= wptr + 1'b1;
            if (!ram_we) err <= 1'b1;
            if ((32'(wptr) + 32'd1 == cfg.load_len) || s_act_tlast) begin
              if (32'(wptr) + 32'd1 != cfg.load_len) err <= 1'b1;
              s_act_tready <= 1'b0;
              if (skip_cfg) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_STREAM;
              end
            end
          end
        end
        ST_STREAM: begin
          if (all_issued && !rd_vld && (fifo_cnt == 2'd1) && pop) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          cfg_ready  <= 1'b1;
          all_issued <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data <= '{default: '0};
      fifo_last <= '0;
      fifo_wsel <= 1'b0;
      fifo_rsel <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      if (rd_vld) begin
        fifo_data[fifo_wsel] <= push_data;
        fifo_last[fifo_wsel] <= rd_last;
        fifo_wsel            <= ~fifo_wsel;
      end
      if (pop) fifo_rsel <= ~fifo_rsel;
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

  assign m_act_tvalid = (fifo_cnt != 2'd0);
  assign m_act_tdata  = fifo_data[fifo_rsel];
  assign m_act_tlast  = fifo_last[fifo_rsel];
  assign status       = state;

endmodule

// File: tb/tb_act_repeat_buffer.sv
// Bench for act_repeat_buffer: table-driven jobs, hand sequences and random jobs,
// each checked against a loop-nest reference model of the replay order.
module tb_act_repeat_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 12;

  logic          clk, rst;
  logic          cfg_valid, cfg_ready;
  logic [AW:0]   cfg_load_len;
  logic [AW-1:0] cfg_line_len, cfg_line_stride;
  logic [CW-1:0] cfg_line_num, cfg_repeat, cfg_full_repeat;
  logic          s_act_tvalid, s_act_tready, s_act_tlast;
  logic [127:0]  s_act_tdata;
  logic          m_act_tvalid, m_act_tready, m_act_tlast;
  logic [63:0]   m_act_tdata;
  logic          done, err;
  logic [1:0]    status;

  act_repeat_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_load_len(cfg_load_len), .cfg_line_len(cfg_line_len),
    .cfg_line_stride(cfg_line_stride), .cfg_line_num(cfg_line_num),
    .cfg_repeat(cfg_repeat), .cfg_full_repeat(cfg_full_repeat),
    .s_act_tvalid(s_act_tvalid), .s_act_tready(s_act_tready),
    .s_act_tdata(s_act_tdata), .s_act_tlast(s_act_tlast),
    .m_act_tvalid(m_act_tvalid), .m_act_tready(m_act_tready),
    .m_act_tdata(m_act_tdata), .m_act_tlast(m_act_tlast),
    .done(done), .err(err), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    int load_len; int tlast_at; int kind;
    int line_len; int stride; int line_num; int rep; int full;
    bit rnd;
    int exp_beats; int exp_tlasts; bit exp_err;
  } vec_t;

  logic [127:0] model_mem [DEPTH];
  logic [127:0] load_words[$];
  beat_t        exp_q[$];
  logic [63:0]  got_d[$];
  int           nload, model_tl, got_beats, got_tlasts;
  bit           model_err;

  function automatic logic [127:0] gen_word(input int kind, input int i);
    logic [127:0] w;
    w = '0;
    case (kind)
      0: for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(i*8 + j);
      1: w = {$urandom, $urandom, $urandom, $urandom};
      default: w = 128'h0000_FFFF_8000_0001_0FFF_F123_07FF_0800;
    endcase
    return w;
  endfunction

  // Reference: explicit loop nest pass/line/repeat/word/sub-beat over a memory image.
  task automatic build_model(input vec_t v);
    int rn, fn, a;
    logic [127:0] w;
    logic [11:0]  f;
    beat_t b;
    bit early;
    early = (v.tlast_at >= 1) && (v.tlast_at < v.load_len);
    nload = early ? v.tlast_at : v.load_len;
    model_err = early;
    load_words.delete();
    for (int i = 0; i < nload; i++) begin
      w = gen_word(v.kind, i);
      load_words.push_back(w);
      if (i < DEPTH) model_mem[i] = w;
      else model_err = 1'b1;
    end
    rn = (v.rep == 0) ? 1 : v.rep;
    fn = (v.full == 0) ? 1 : v.full;
    exp_q.delete();
    model_tl = 0;
    for (int p = 0; p < fn; p++)
      for (int ln = 0; ln < v.line_num; ln++)
        for (int r = 0; r < rn; r++)
          for (int wi = 0; wi < v.line_len; wi++)
            for (int g = 0; g < 2; g++) begin
              a = ln * v.stride + wi;
              if (a >= DEPTH) model_err = 1'b1;
              w = model_mem[a % DEPTH];
              for (int k = 0; k < 4; k++) begin
                f = w[(g*4 + k)*16 +: 12];
                b.d[k*16 +: 16] = {{4{f[11]}}, f};
              end
              b.l = (wi == v.line_len - 1) && (g == 1);
              if (b.l) model_tl++;
              exp_q.push_back(b);
            end
  endtask

  task automatic do_cfg(input vec_t v);
    int cyc = 0;
    while (!cfg_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("cfg_ready_wait", cfg_ready, 1);
    done_cnt        = 0;
    cfg_valid       = 1'b1;
    cfg_load_len    = (AW+1)'(v.load_len);
    cfg_line_len    = AW'(v.line_len);
    cfg_line_stride = AW'(v.stride);
    cfg_line_num    = CW'(v.line_num);
    cfg_repeat      = CW'(v.rep);
    cfg_full_repeat = CW'(v.full);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("err_cleared", err, 0);
    chk("cfg_ready_busy", cfg_ready, 0);
    chk("s_tready_start", s_act_tready, (v.load_len != 0) ? 1 : 0);
  endtask

  task automatic do_load(input vec_t v);
    int i = 0;
    int cyc = 0;
    logic rdy;
    while (i < nload && cyc < 4*nload + 20) begin
      s_act_tvalid = 1'b1;
      s_act_tdata  = load_words[i];
      s_act_tlast  = (v.tlast_at > 0) && (i + 1 == v.tlast_at);
      rdy = s_act_tready;
      @(posedge clk);
      if (rdy) i++;
      @(negedge clk);
      cyc++;
    end
    s_act_tvalid = 1'b0;
    s_act_tlast  = 1'b0;
    chk("load_beats", i, nload);
    if (nload > 0) chk("s_tready_end", s_act_tready, 0);
  endtask

  task automatic consume(input bit rnd);
    int cyc = 0;
    int extra = 0;
    int limit;
    logic r, vv, l, pv, pr, pl;
    logic [63:0] d, pd;
    bit fin;
    limit = 40 + 4 * exp_q.size();
    got_beats = 0; got_tlasts = 0; got_d.delete();
    pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0; fin = 1'b0;
    while (cyc < limit) begin
      r  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_act_tready = r;
      vv = m_act_tvalid; d = m_act_tdata; l = m_act_tlast;
      if (pv && !pr) begin
        chk("hold_valid", vv, 1);
        chk("hold_data", d, pd);
        chk("hold_last", l, pl);
      end
      if (vv && r) begin
        if (got_beats < exp_q.size()) begin
          chk("beat_data", d, exp_q[got_beats].d);
          chk("beat_last", l, exp_q[got_beats].l);
        end else begin
          chk("extra_beat", 1, 0);
        end
        got_d.push_back(d);
        got_beats++;
        if (l) got_tlasts++;
      end
      pv = vv; pr = r; pd = d; pl = l;
      @(negedge clk);
      cyc++;
      if (got_beats >= exp_q.size() && done_cnt > 0) begin
        fin = 1'b1;
        extra++;
        if (extra > 4) break;
      end
    end
    m_act_tready = 1'b0;
    chk("job_finished", fin, 1);
    chk("done_pulses", done_cnt, 1);
    chk("status_idle", status, 0);
    chk("cfg_ready_after", cfg_ready, 1);
  endtask

  task automatic run_job(input vec_t v);
    build_model(v);
    do_cfg(v);
    do_load(v);
    consume(v.rnd);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{8, 8, 0,  2, 2, 4, 3, 1,  0, 48, 12, 0};
    tbl[1] = '{8, 8, 0,  2, 2, 4, 3, 1,  1, 48, 12, 0};
    tbl[2] = '{8, 8, 0,  2, 2, 4, 0, 2,  0, 32,  8, 0};
    tbl[3] = '{8, 3, 1,  3, 0, 1, 1, 1,  0,  6,  1, 1};
    tbl[4] = '{4, 0, 1,  4, 0, 1, 2, 1,  1, 16,  2, 0};
    tbl[5] = '{1, 1, 2,  1, 0, 1, 1, 1,  0,  2,  1, 0};
    tbl[6] = '{18, 18, 0, 4, 0, 1, 2, 1, 0, 16,  2, 1};
    tbl[7] = '{0, 0, 0,  4, 14, 2, 1, 1, 0, 16,  2, 1};
    tbl[8] = '{2, 2, 1,  2, 0, 0, 1, 1,  0,  0,  0, 0};
    tbl[9] = '{0, 0, 0,  0, 1, 1, 1, 1,  0,  0,  0, 0};

    rst = 1'b1; cfg_valid = 1'b0; cfg_load_len = '0; cfg_line_len = '0;
    cfg_line_stride = '0; cfg_line_num = '0; cfg_repeat = '0; cfg_full_repeat = '0;
    s_act_tvalid = 1'b0; s_act_tdata = '0; s_act_tlast = 1'b0; m_act_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_s_tready", s_act_tready, 0);
    chk("rst_m_tvalid", m_act_tvalid, 0);
    chk("rst_m_tdata", m_act_tdata, 0);
    chk("rst_m_tlast", m_act_tlast, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_status", status, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      run_job(tbl[t]);
      chk("job_beats", got_beats, tbl[t].exp_beats);
      chk("job_tlasts", got_tlasts, tbl[t].exp_tlasts);
      chk("job_err", err, tbl[t].exp_err);
      if (tbl[t].kind == 2 && got_d.size() >= 2) begin
        chk("sext_beat0", got_d[0], 64'hFFFF_0123_07FF_F800);
        chk("sext_beat1", got_d[1], 64'h0000_FFFF_0000_0001);
      end
    end

    // Abort a job mid-stream with reset: outputs drop at once, no done pulse.
    build_model(tbl[0]);
    do_cfg(tbl[0]);
    do_load(tbl[0]);
    m_act_tready = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_valid", m_act_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", m_act_tvalid, 0);
    chk("midrst_status", status, 0);
    @(negedge clk);
    rst = 1'b0;
    m_act_tready = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_tvalid_idle", m_act_tvalid, 0);
    run_job(tbl[0]);
    chk("recover_beats", got_beats, tbl[0].exp_beats);

    for (int n = 0; n < 6; n++) begin
      rv.load_len = int'($urandom_range(1, 16));
      rv.tlast_at = ($urandom_range(0, 3) == 0) ? 0 : rv.load_len;
      rv.kind     = 1;
      rv.line_len = int'($urandom_range(1, 4));
      rv.stride   = int'($urandom_range(0, 5));
      rv.line_num = int'($urandom_range(1, 3));
      rv.rep      = int'($urandom_range(0, 2));
      rv.full     = int'($urandom_range(0, 2));
      rv.rnd      = 1'b1;
      rv.exp_beats = 0; rv.exp_tlasts = 0; rv.exp_err = 1'b0;
      run_job(rv);
      chk("rnd_beats", got_beats, exp_q.size());
      chk("rnd_tlasts", got_tlasts, model_tl);
      chk("rnd_err", err, model_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
